// File: rtl/router_out_fifo.sv
// Per-port output buffer of the 1x3 router; stores header-tagged packet bytes.
// Latency: 1 cycle from accepted read to data_out; full/empty are combinational.
// Backpressure: writes while full are dropped, reads while empty are ignored.
//
// Ports:
//   clk, rst (sync, active-low), soft_reset (sync flush, active-high)
//   write_enb/lfd_state/data_in : write side, lfd_state tags a header byte
//   read_enb/data_out           : read side, data_out registered
//   full, empty                 : occupancy flags for the synchronizer
//   level (only with ROUTER_FIFO_LEVEL_EN defined) : current entry count
module router_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      level
`endif
);

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [WIDTH-2:0] CNT_ONE = 1;

  // Bit WIDTH of each entry is the header marker captured with the byte.
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-2:0] pkt_cnt;
  logic [WIDTH:0]   rd_word;
  logic [WIDTH-2:0] hdr_cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic             flush;

  assign flush   = !rst || soft_reset;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_acc  = write_enb && !full;
  assign rd_acc  = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];
  // Header carries payload length; +1 covers the trailing parity byte.
  assign hdr_cnt = {1'b0, rd_word[WIDTH-1:2]} + CNT_ONE;

`ifdef ROUTER_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

  // Storage is not cleared on flush: stale entries are unreachable while empty.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rd_word[WIDTH-1:0];
        // A header always reloads, even mid-packet, so a malformed stream resyncs.
        if (rd_word[WIDTH]) begin
          pkt_cnt <= hdr_cnt;
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - CNT_ONE;
        end
      end else if (pkt_cnt == '0) begin
        // Outside a packet the port idles at zero.
        data_out <= '0;
      end
    end
  end

endmodule
